// File: rtl/uart_tx_arbiter.sv
// Two-requester byte arbiter in front of a single UART transmitter.
// Each requester owns a small FIFO; a round-robin scheduler issues one byte
// per UART frame and never strobes the UART while a frame is in flight.

// Per-requester FIFO: power-of-two depth, wrapping pointers, no bypass.
module uart_tx_fifo #(
  parameter int AW = 2,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] push_data,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          empty
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [AW:0]              count;
  logic                     do_push, do_pop;

  // Ready depends only on the count, so a full FIFO stays full even while popped.
  assign push_ready = (count != FULL);
  assign empty      = (count == '0);
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && !empty;
  assign head       = mem[rd_ptr];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module uart_tx_arbiter #(
  parameter int FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  output logic [7:0] uart_wr_data,
  output logic       uart_wr_en,
  input  logic       uart_busy,
  output logic       idle
);
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  state_t                    state;
  logic                      last_grant;
  logic                      grant;
  logic                      any;
  logic                      issue;
  logic [NUM_REQ-1:0][7:0]   in_data, head;
  logic [NUM_REQ-1:0]        in_valid, in_ready, empty, pop;

  assign in_data  = {req1_data, req0_data};
  assign in_valid = {req1_valid, req0_valid};
  assign req0_ready = in_ready[0];
  assign req1_ready = in_ready[1];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
    uart_tx_fifo #(.AW(FIFO_AW), .DW(8)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_data  (in_data[g]),
      .push_valid (in_valid[g]),
      .push_ready (in_ready[g]),
      .pop        (pop[g]),
      .head       (head[g]),
      .empty      (empty[g])
    );
  end

  // Round-robin pick: on a tie the requester not served last wins.
  always_comb begin
    any   = |(~empty);
    grant = 1'b0;
    if (!empty[0] && !empty[1]) grant = ~last_grant;
    else                        grant = !empty[1];
  end

  // Pop happens in the same cycle the byte is latched into uart_wr_data.
  assign issue = (state == S_IDLE) && !uart_busy && any;
  assign pop   = issue ? (grant ? 2'b10 : 2'b01) : 2'b00;

  assign idle = (&empty) && (state == S_IDLE) && !uart_busy;

  // Issue FSM: one strobe per frame, then wait for the UART to drop busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      last_grant   <= 1'b1;
      uart_wr_en   <= 1'b0;
      uart_wr_data <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue) begin
            uart_wr_data <= head[grant];
            uart_wr_en   <= 1'b1;
            last_grant   <= grant;
            state        <= S_SEND;
          end
        end
        S_SEND: begin
          uart_wr_en <= 1'b0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (!uart_busy) state <= S_IDLE;
        end
        default: begin
          uart_wr_en <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART busy model and a
// byte scoreboard checked at every write strobe.
module tb_uart_tx_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req0_data, req1_data;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] uart_wr_data;
  logic       uart_wr_en;
  logic       uart_busy;
  logic       idle;

  logic       ext_busy;
  int         frame_len;
  int         busy_cnt;
  int         pulses;
  logic       wr_en_prev;
  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.FIFO_AW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .uart_wr_data(uart_wr_data), .uart_wr_en(uart_wr_en),
    .uart_busy(uart_busy), .idle(idle)
  );

  // UART model: busy for frame_len cycles after sampling a strobe.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          busy_cnt <= 0;
    else if (uart_wr_en) busy_cnt <= frame_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign uart_busy = ext_busy || (busy_cnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: scoreboard order, one-cycle pulses, never while busy.
  always @(negedge clk) begin
    if (rst_n && uart_wr_en) begin
      pulses++;
      check("wr_en_pulse_width", {31'd0, wr_en_prev}, 32'd0);
      check("strobe_while_busy", {31'd0, uart_busy}, 32'd0);
      n_total++;
      assert (sb.size() != 0) begin
        n_pass++;
        check("byte_order", {24'd0, uart_wr_data}, {24'd0, sb.pop_front()});
      end else begin
        $error("FAIL unexpected_byte: observed 0x%0h expected none", uart_wr_data);
      end
    end
    wr_en_prev = rst_n && uart_wr_en;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Push one byte on requester r, holding valid until ready (bounded).
  task automatic push(input int r, input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    if (r == 0) begin req0_data = d; req0_valid = 1'b1; end
    else        begin req1_data = d; req1_valid = 1'b1; end
    while (!(r == 0 ? req0_ready : req1_ready) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("push_ready_timeout", {31'd0, (r == 0 ? req0_ready : req1_ready)}, 32'd1);
    if (r == 0 ? req0_ready : req1_ready) sb.push_back(d);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int limit);
    int t = 0;
    while (!(idle && sb.size() == 0) && t < limit) begin
      @(negedge clk);
      t++;
    end
    check(tag, {31'd0, idle}, 32'd1);
    check({tag, "_sb_left"}, sb.size(), 32'd0);
  endtask

  initial begin
    int p0;
    rst_n = 1'b0; ext_busy = 1'b0; frame_len = 8;
    req0_data = 8'h00; req1_data = 8'h00; req0_valid = 1'b0; req1_valid = 1'b0;
    pulses = 0; wr_en_prev = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_wr_en", {31'd0, uart_wr_en}, 32'd0);
    check("rst_wr_data", {24'd0, uart_wr_data}, 32'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready0", {31'd0, req0_ready}, 32'd1);
    check("rst_ready1", {31'd0, req1_ready}, 32'd1);
    check("rst_idle", {31'd0, idle}, 32'd1);

    // 1: single byte latency; the UART samples the strobe at push edge + 2
    @(negedge clk);
    req0_data = 8'h41; req0_valid = 1'b1; sb.push_back(8'h41);
    @(negedge clk);
    req0_valid = 1'b0;
    check("t1_no_early_strobe", {31'd0, uart_wr_en}, 32'd0);
    check("t1_idle_low_queued", {31'd0, idle}, 32'd0);
    @(negedge clk);
    check("t1_strobe", {31'd0, uart_wr_en}, 32'd1);
    check("t1_data", {24'd0, uart_wr_data}, 32'h41);
    @(negedge clk);
    check("t1_strobe_end", {31'd0, uart_wr_en}, 32'd0);
    check("t1_busy", {31'd0, uart_busy}, 32'd1);
    check("t1_idle_low_busy", {31'd0, idle}, 32'd0);
    check("t1_data_held", {24'd0, uart_wr_data}, 32'h41);
    wait_drain("t1_drain", 200);

    // 2: simultaneous pushes interleave round-robin after reset
    do_reset();
    p0 = pulses;
    @(negedge clk);
    req0_data = 8'h30; req1_data = 8'h60; req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    req0_data = 8'h31; req1_data = 8'h61;
    sb.push_back(8'h30); sb.push_back(8'h60); sb.push_back(8'h31); sb.push_back(8'h61);
    drop_valid();
    wait_drain("t2_drain", 400);
    check("t2_pulses", pulses - p0, 32'd4);

    // 3: external busy holds issue; fifth byte refused when full
    ext_busy = 1'b1;
    p0 = pulses;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req1_data = 8'hA0 + 8'(i); req1_valid = 1'b1;
      check($sformatf("t3_ready_%0d", i), {31'd0, req1_ready}, (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) sb.push_back(8'hA0 + 8'(i));
    end
    drop_valid();
    repeat (5) @(negedge clk);
    check("t3_held", pulses - p0, 32'd0);
    check("t3_still_full", {31'd0, req1_ready}, 32'd0);
    ext_busy = 1'b0;
    wait_drain("t3_drain", 400);
    check("t3_pulses", pulses - p0, 32'd4);

    // 4: long frames, three bytes queued
    frame_len = 48;
    p0 = pulses;
    push(0, 8'hB0); push(0, 8'hB1); push(0, 8'hB2);
    drop_valid();
    wait_drain("t4_drain", 1000);
    check("t4_pulses", pulses - p0, 32'd3);

    // 5: reset during WAIT with two bytes still queued
    push(0, 8'hC0); push(0, 8'hC1); push(0, 8'hC2);
    drop_valid();
    repeat (6) @(negedge clk);
    check("t5_in_frame", {31'd0, uart_busy}, 32'd1);
    check("t5_first_sent", sb.size(), 32'd2);
    do_reset();
    p0 = pulses;
    check("t5_wr_en", {31'd0, uart_wr_en}, 32'd0);
    check("t5_ready0", {31'd0, req0_ready}, 32'd1);
    check("t5_ready1", {31'd0, req1_ready}, 32'd1);
    check("t5_idle", {31'd0, idle}, 32'd1);
    repeat (100) @(negedge clk);
    check("t5_no_stale", pulses - p0, 32'd0);

    // 6: pointer wrap with back-pressure
    frame_len = 6;
    p0 = pulses;
    for (int i = 0; i < 10; i++) push(0, 8'(i));
    drop_valid();
    wait_drain("t6_drain", 1000);
    check("t6_pulses", pulses - p0, 32'd10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
